// File: rtl/sparse_chunk_loader_pkg.sv
// Shared types and defaults for the sparse chunk loader.
// Global defines, when present, override the built-in defaults.
`ifndef BUS_SIZE
`define BUS_SIZE 32
`endif
`ifndef WR_DAT_CYC_NUM
`define WR_DAT_CYC_NUM 4
`endif
`ifndef SRAM_NUM
`define SRAM_NUM 16
`endif

package sparse_chunk_loader_pkg;

    localparam int BUS_SIZE_DEF       = `BUS_SIZE;
    localparam int WR_DAT_CYC_NUM_DEF = `WR_DAT_CYC_NUM;
    localparam int SRAM_NUM_DEF       = `SRAM_NUM;

    // Counter width that never collapses to zero bits.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DAT_CNT_W    = cnt_w(WR_DAT_CYC_NUM_DEF);
    localparam int CHUNK_CNT_W  = cnt_w(SRAM_NUM_DEF);
    localparam int NUM_CHUNKS_W = CHUNK_CNT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef logic [DAT_CNT_W-1:0]    dat_cnt_t;
    typedef logic [CHUNK_CNT_W-1:0]  chunk_cnt_t;
    typedef logic [NUM_CHUNKS_W-1:0] num_chunks_t;

endpackage

// File: rtl/sparse_chunk_loader_if.sv
// Control, dense-stream and SRAM-write signals of one loader instance.
// master = feeder/consumer side, slave = loader side.
interface sparse_chunk_loader_if
    import sparse_chunk_loader_pkg::*;
#(
    parameter int BUS_SIZE       = BUS_SIZE_DEF,
    parameter int WR_DAT_CYC_NUM = WR_DAT_CYC_NUM_DEF,
    parameter int SRAM_NUM       = SRAM_NUM_DEF
) ();
    localparam int DCW = cnt_w(WR_DAT_CYC_NUM);
    localparam int CCW = cnt_w(SRAM_NUM);
    localparam int NCW = CCW + 1;

    logic                  start_i;
    logic [NCW-1:0]        num_chunks_i;
    logic                  dense_valid_i;
    logic [BUS_SIZE*8-1:0] dense_dat_i;
    logic                  dense_rdy_o;
    logic                  wr_valid_o;
    logic [BUS_SIZE-1:0]   wr_sparsemap_o;
    logic [BUS_SIZE*8-1:0] wr_nonzero_data_o;
    logic [DCW-1:0]        wr_dat_count_o;
    logic [CCW-1:0]        wr_chunk_count_o;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        output start_i, num_chunks_i, dense_valid_i, dense_dat_i,
        input  dense_rdy_o, wr_valid_o, wr_sparsemap_o, wr_nonzero_data_o,
               wr_dat_count_o, wr_chunk_count_o, busy_o, done_o
    );

    modport slave (
        input  start_i, num_chunks_i, dense_valid_i, dense_dat_i,
        output dense_rdy_o, wr_valid_o, wr_sparsemap_o, wr_nonzero_data_o,
               wr_dat_count_o, wr_chunk_count_o, busy_o, done_o
    );
endinterface

// File: rtl/sparse_chunk_loader_packer.sv
// Combinational zero-byte compressor: sparsemap plus nonzero bytes packed from byte 0 upward.
// Zero latency, no flow control.
module sparse_byte_packer
    import sparse_chunk_loader_pkg::*;
#(
    parameter int BUS_SIZE = BUS_SIZE_DEF
) (
    input  logic [BUS_SIZE*8-1:0] dense_dat,
    output logic [BUS_SIZE-1:0]   sparsemap,
    output logic [BUS_SIZE*8-1:0] packed_dat
);
    localparam int IW = $clog2(BUS_SIZE + 1);

    // rank[j] = number of nonzero bytes strictly below byte j = its packed slot.
    logic [IW-1:0] rank [BUS_SIZE];

    always_comb begin
        logic [IW-1:0] acc;
        acc       = '0;
        sparsemap = '0;
        for (int j = 0; j < BUS_SIZE; j++) begin
            sparsemap[j] = |dense_dat[8*j +: 8];
            rank[j]      = acc;
            acc          = acc + IW'(sparsemap[j]);
        end
    end

    // Output byte k can only come from source byte j >= k.
    always_comb begin
        packed_dat = '0;
        for (int k = 0; k < BUS_SIZE; k++) begin
            for (int j = k; j < BUS_SIZE; j++) begin
                if (sparsemap[j] && (rank[j] == IW'(k)))
                    packed_dat[8*k +: 8] = packed_dat[8*k +: 8] | dense_dat[8*j +: 8];
            end
        end
    end
endmodule

// File: rtl/sparse_chunk_loader.sv
// Loads num_chunks x WR_DAT_CYC_NUM dense beats into SRAM as sparsemap + packed nonzero bytes.
// One register stage (accept at N -> write at N+1); rdy high only in LOAD, SRAM never stalls.
module sparse_chunk_loader
    import sparse_chunk_loader_pkg::*;
#(
    parameter int BUS_SIZE       = BUS_SIZE_DEF,
    parameter int WR_DAT_CYC_NUM = WR_DAT_CYC_NUM_DEF,
    parameter int SRAM_NUM       = SRAM_NUM_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    sparse_chunk_loader_if.slave  bus
);
    localparam int DCW = cnt_w(WR_DAT_CYC_NUM);
    localparam int CCW = cnt_w(SRAM_NUM);
    localparam int NCW = CCW + 1;

    state_e                state;
    logic [DCW-1:0]        beat_cnt;
    logic [CCW-1:0]        chunk_cnt;
    logic [NCW-1:0]        chunks_done;
    logic [NCW-1:0]        target;

    logic [BUS_SIZE-1:0]   pk_smap;
    logic [BUS_SIZE*8-1:0] pk_dat;

    logic xfer;
    logic beat_last;
    logic chunk_wrap;
    logic final_chunk;

    sparse_byte_packer #(.BUS_SIZE(BUS_SIZE)) u_packer (
        .dense_dat  (bus.dense_dat_i),
        .sparsemap  (pk_smap),
        .packed_dat (pk_dat)
    );

    assign xfer        = (state == ST_LOAD) && bus.dense_valid_i && bus.dense_rdy_o;
    assign beat_last   = (beat_cnt == DCW'(WR_DAT_CYC_NUM - 1));
    assign chunk_wrap  = (chunk_cnt == CCW'(SRAM_NUM - 1));
    assign final_chunk = (chunks_done == (target - NCW'(1)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state                 <= ST_IDLE;
            beat_cnt              <= '0;
            chunk_cnt             <= '0;
            chunks_done           <= '0;
            target                <= '0;
            bus.dense_rdy_o       <= 1'b0;
            bus.wr_valid_o        <= 1'b0;
            bus.wr_sparsemap_o    <= '0;
            bus.wr_nonzero_data_o <= '0;
            bus.wr_dat_count_o    <= '0;
            bus.wr_chunk_count_o  <= '0;
            bus.busy_o            <= 1'b0;
            bus.done_o            <= 1'b0;
        end else begin
            bus.wr_valid_o <= 1'b0;
            bus.done_o     <= 1'b0;

            // Write carries the counts that were current when the beat was accepted.
            if (xfer) begin
                bus.wr_valid_o        <= 1'b1;
                bus.wr_sparsemap_o    <= pk_smap;
                bus.wr_nonzero_data_o <= pk_dat;
                bus.wr_dat_count_o    <= beat_cnt;
                bus.wr_chunk_count_o  <= chunk_cnt;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        if (bus.num_chunks_i != '0) begin
                            state           <= ST_LOAD;
                            target          <= bus.num_chunks_i;
                            beat_cnt        <= '0;
                            chunk_cnt       <= '0;
                            chunks_done     <= '0;
                            bus.dense_rdy_o <= 1'b1;
                            bus.busy_o      <= 1'b1;
                        end else begin
                            bus.done_o <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        if (beat_last) begin
                            beat_cnt    <= '0;
                            chunk_cnt   <= chunk_wrap ? '0 : chunk_cnt + CCW'(1);
                            chunks_done <= chunks_done + NCW'(1);
                            // Drop rdy with the state change so no extra beat slips in.
                            if (final_chunk) begin
                                state           <= ST_DRAIN;
                                bus.dense_rdy_o <= 1'b0;
                                bus.done_o      <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + DCW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    state      <= ST_IDLE;
                    bus.busy_o <= 1'b0;
                end
                default: begin
                    state           <= ST_IDLE;
                    bus.dense_rdy_o <= 1'b0;
                    bus.busy_o      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sparse_chunk_loader.sv
// Randomized bench for sparse_chunk_loader with a queue-based reference model and scoreboard.
module tb_sparse_chunk_loader;
    localparam int BS  = 8;
    localparam int W   = 4;
    localparam int S   = 16;
    localparam int NCW = 5;

    typedef struct {
        logic            valid;
        logic            done;
        logic [BS-1:0]   smap;
        logic [BS*8-1:0] data;
        int              dat;
        int              chunk;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    exp_t expq[$];

    sparse_chunk_loader_if #(.BUS_SIZE(BS), .WR_DAT_CYC_NUM(W), .SRAM_NUM(S)) bus ();

    sparse_chunk_loader #(.BUS_SIZE(BS), .WR_DAT_CYC_NUM(W), .SRAM_NUM(S)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: collect nonzero bytes in source order, lay them out from byte 0.
    function automatic void ref_pack(input logic [BS*8-1:0] beat,
                                     output logic [BS-1:0] smap,
                                     output logic [BS*8-1:0] data);
        logic [7:0] nz[$];
        smap = '0;
        data = '0;
        for (int i = 0; i < BS; i++) begin
            if (beat[8*i +: 8] != 8'h00) begin
                smap[i] = 1'b1;
                nz.push_back(beat[8*i +: 8]);
            end
        end
        for (int k = 0; k < nz.size(); k++) data[8*k +: 8] = nz[k];
    endfunction

    function automatic logic [BS*8-1:0] gen_beat();
        logic [BS*8-1:0] b;
        int sel;
        sel = $urandom_range(0, 7);
        for (int i = 0; i < BS; i++) begin
            if (sel == 0)      b[8*i +: 8] = 8'h00;
            else if (sel == 1) b[8*i +: 8] = 8'($urandom_range(1, 255));
            else               b[8*i +: 8] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
        end
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: back-to-back, 1: one idle cycle between beats, 2: random gaps.
    task automatic run_load(input int n, input int mode, input int abort_after, input bit directed);
        int   total;
        int   gaps;
        exp_t e;
        logic [BS*8-1:0] beat;
        total = n * W;
        bus.start_i      = 1'b1;
        bus.num_chunks_i = NCW'(n);
        if (n == 0) begin
            e = '{valid: 1'b0, done: 1'b1, smap: '0, data: '0, dat: 0, chunk: 0};
            expq.push_back(e);
        end
        tick();
        bus.start_i = 1'b0;
        if (n == 0) begin
            chk("zero_busy", bus.busy_o, 0);
            chk("zero_rdy", bus.dense_rdy_o, 0);
            tick();
            tick();
            return;
        end
        chk("start_busy", bus.busy_o, 1);
        for (int b = 0; b < total; b++) begin
            if (b == abort_after) begin
                bus.dense_valid_i = 1'b0;
                @(negedge clk);
                #1;
                rst = 1'b1;
                #1;
                chk("arst_wr_valid", bus.wr_valid_o, 0);
                chk("arst_busy", bus.busy_o, 0);
                chk("arst_rdy", bus.dense_rdy_o, 0);
                chk("arst_done", bus.done_o, 0);
                chk("arst_dat_count", bus.wr_dat_count_o, 0);
                chk("arst_smap", bus.wr_sparsemap_o, 0);
                tick();
                rst = 1'b0;
                tick();
                chk("post_arst_busy", bus.busy_o, 0);
                return;
            end
            gaps = (mode == 1 && b > 0) ? 1 : (mode == 2) ? $urandom_range(0, 2) : 0;
            for (int g = 0; g < gaps; g++) begin
                bus.dense_valid_i = 1'b0;
                bus.dense_dat_i   = gen_beat();
                bus.start_i       = ($urandom_range(0, 2) == 0);
                bus.num_chunks_i  = NCW'($urandom_range(0, 31));
                tick();
                bus.start_i = 1'b0;
            end
            chk("rdy_in_load", bus.dense_rdy_o, 1);
            beat = (directed && b == 0) ? 64'h0000_0000_0007_0005 : gen_beat();
            e.valid = 1'b1;
            e.done  = (b == total - 1);
            e.dat   = b % W;
            e.chunk = (b / W) % S;
            if (directed && b == 0) begin
                e.smap = 8'b0000_0101;
                e.data = 64'h0000_0000_0000_0705;
            end else begin
                ref_pack(beat, e.smap, e.data);
            end
            expq.push_back(e);
            bus.dense_dat_i   = beat;
            bus.dense_valid_i = 1'b1;
            tick();
        end
        chk("drain_rdy", bus.dense_rdy_o, 0);
        chk("drain_busy", bus.busy_o, 1);
        // Beat offered and start pulsed while draining: both must be ignored.
        bus.dense_dat_i   = gen_beat();
        bus.start_i       = 1'b1;
        bus.num_chunks_i  = NCW'(3);
        tick();
        bus.start_i = 1'b0;
        chk("idle_busy", bus.busy_o, 0);
        chk("idle_rdy", bus.dense_rdy_o, 0);
        tick();
        bus.dense_valid_i = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (bus.wr_valid_o || bus.done_o)) begin
            if (expq.size() == 0) begin
                chk("unexpected_output", {62'd0, bus.wr_valid_o, bus.done_o}, 64'd0);
            end else begin
                e = expq.pop_front();
                chk("wr_valid", bus.wr_valid_o, e.valid);
                chk("done", bus.done_o, e.done);
                if (e.valid) begin
                    chk("sparsemap", bus.wr_sparsemap_o, e.smap);
                    chk("nonzero_data", bus.wr_nonzero_data_o, e.data);
                    chk("dat_count", bus.wr_dat_count_o, e.dat);
                    chk("chunk_count", bus.wr_chunk_count_o, e.chunk);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst               = 1'b1;
        bus.start_i       = 1'b0;
        bus.num_chunks_i  = '0;
        bus.dense_valid_i = 1'b0;
        bus.dense_dat_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wr_valid", bus.wr_valid_o, 0);
        chk("reset_rdy", bus.dense_rdy_o, 0);
        chk("reset_busy", bus.busy_o, 0);
        chk("reset_done", bus.done_o, 0);
        rst = 1'b0;
        tick();

        run_load(2, 0, -1, 1'b1);
        run_load(2, 1, -1, 1'b0);
        run_load(17, 2, -1, 1'b0);
        run_load(0, 0, -1, 1'b0);
        run_load(2, 0, 3, 1'b0);
        run_load(1, 0, -1, 1'b0);
        for (int i = 0; i < 6; i++) run_load($urandom_range(0, 5), 2, -1, 1'b0);

        repeat (3) tick();
        chk("queue_empty", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
